// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit holding HI/LO, with stall request to decode.
// Define MDU_MADD_EN to enable madd/maddu (codes 9/10); otherwise those codes act as none.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp_E,
    input  logic [31:0] SrcA_E,
    input  logic [31:0] SrcB_E,
    input  logic        MDUUse_D,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut_E,
    output logic        MDU_Stall
);
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;
    logic        is_mul, is_div, is_madd, sgn, start;
    logic [63:0] ext_a, ext_b, prod, mres;
    logic [31:0] a_abs, b_abs, q_abs, r_abs, quo, rem;
    always_comb begin
        is_mul = MDUOp_E == 4'd1 || MDUOp_E == 4'd2;
        is_div = MDUOp_E == 4'd3 || MDUOp_E == 4'd4;
`ifdef MDU_MADD_EN
        is_madd = MDUOp_E == 4'd9 || MDUOp_E == 4'd10;
`else
        is_madd = 1'b0;
`endif
        sgn = MDUOp_E == 4'd1 || MDUOp_E == 4'd3 || MDUOp_E == 4'd9;
        start = (is_mul || is_div || is_madd) && !Busy;
        ext_a = {{32{sgn & SrcA_E[31]}}, SrcA_E};
        ext_b = {{32{sgn & SrcB_E[31]}}, SrcB_E};
        prod = ext_a * ext_b;
        mres = is_madd ? {HI, LO} + prod : prod;
        // Divide on magnitudes so INT_MIN / -1 wraps cleanly instead of overflowing
        a_abs = (sgn & SrcA_E[31]) ? -SrcA_E : SrcA_E;
        b_abs = (sgn & SrcB_E[31]) ? -SrcB_E : SrcB_E;
        q_abs = (b_abs == 32'd0) ? 32'd0 : a_abs / b_abs;
        r_abs = (b_abs == 32'd0) ? 32'd0 : a_abs % b_abs;
        quo = (sgn & (SrcA_E[31] ^ SrcB_E[31])) ? -q_abs : q_abs;
        rem = (sgn & SrcA_E[31]) ? -r_abs : r_abs;
        MDUOut_E = MDUOp_E == 4'd5 ? HI : MDUOp_E == 4'd6 ? LO : 32'd0;
        MDU_Stall = MDUUse_D & (start | Busy);
    end
    assign Busy = cnt != 4'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (start) begin
            cnt <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            pend_hi <= is_div ? rem : mres[63:32];
            pend_lo <= is_div ? quo : mres[31:0];
            pend_wr <= !is_div || SrcB_E != 32'd0;
        end else if (Busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
        end else begin
            if (MDUOp_E == 4'd7) HI <= SrcA_E;
            if (MDUOp_E == 4'd8) LO <= SrcA_E;
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed vector table plus hand sequences for stall, ignore-while-busy and reset abort.
module tb_e_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUOp_E;
    logic [31:0] SrcA_E, SrcB_E;
    logic        MDUUse_D;
    logic        Busy, MDU_Stall;
    logic [31:0] HI, LO, MDUOut_E;
    int checks = 0;
    int errors = 0;

    e_mdu dut (
        .clk(clk), .reset(reset), .MDUOp_E(MDUOp_E), .SrcA_E(SrcA_E), .SrcB_E(SrcB_E),
        .MDUUse_D(MDUUse_D), .Busy(Busy), .HI(HI), .LO(LO), .MDUOut_E(MDUOut_E),
        .MDU_Stall(MDU_Stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t v[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] eh, input logic [31:0] el);
        int k;
        @(negedge clk);
        MDUOp_E = op; SrcA_E = a; SrcB_E = b;
        @(negedge clk);
        MDUOp_E = 4'd0;
        k = 0;
        while (Busy && k < 20) begin
            k++;
            @(negedge clk);
        end
        check("busy_len", 32'(k), 32'(n));
        check("hi", HI, eh);
        check("lo", LO, el);
        MDUOp_E = 4'd5;
        #1 check("mfhi", MDUOut_E, eh);
        MDUOp_E = 4'd6;
        #1 check("mflo", MDUOut_E, el);
        MDUOp_E = 4'd0;
    endtask

    initial begin
        int k;
        v[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        v[1]  = '{4'd2, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
        v[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        v[3]  = '{4'd4, 32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
        v[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        v[5]  = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
        v[6]  = '{4'd4, 32'hFFFFFFFF, 32'h10,       10, 32'h0000000F, 32'h0FFFFFFF};
        v[7]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        v[8]  = '{4'd7, 32'h11111111, 32'd0,        0,  32'h11111111, 32'hFFFFFFFD};
        v[9]  = '{4'd8, 32'h22222222, 32'd0,        0,  32'h11111111, 32'h22222222};
        v[10] = '{4'd8, 32'h12345678, 32'd0,        0,  32'h11111111, 32'h12345678};
        v[11] = '{4'd3, 32'd5,        32'd0,        10, 32'h11111111, 32'h12345678};

        reset = 1'b1; MDUOp_E = 4'd0; SrcA_E = 32'd0; SrcB_E = 32'd0; MDUUse_D = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        for (int i = 0; i < 12; i++)
            do_op(v[i].op, v[i].a, v[i].b, v[i].n, v[i].eh, v[i].el);

        // mult with mflo waiting in decode: stall in t..t+5, then read product
        @(negedge clk);
        MDUOp_E = 4'd1; SrcA_E = 32'd6; SrcB_E = 32'd7; MDUUse_D = 1'b1;
        #1 check("stall_start", 32'(MDU_Stall), 32'd1);
        @(negedge clk);
        MDUOp_E = 4'd0;
        k = 0;
        while (MDU_Stall && k < 20) begin
            k++;
            @(negedge clk);
        end
        check("stall_len", 32'(k), 32'd5);
        MDUOp_E = 4'd6; MDUUse_D = 1'b0;
        #1 check("mflo_prod", MDUOut_E, 32'd42);
        check("hi_prod", HI, 32'd0);

        // start-class op and mthi while busy are ignored
        @(negedge clk);
        MDUOp_E = 4'd1; SrcA_E = 32'd3; SrcB_E = 32'd4;
        @(negedge clk);
        check("busy_t1", 32'(Busy), 32'd1);
        MDUOp_E = 4'd3; SrcA_E = 32'd100; SrcB_E = 32'd7;
        @(negedge clk);
        MDUOp_E = 4'd7; SrcA_E = 32'h0000AAAA;
        @(negedge clk);
        MDUOp_E = 4'd0;
        k = 0;
        while (Busy && k < 20) begin
            k++;
            @(negedge clk);
        end
        check("ign_busy_len", 32'(k), 32'd3);
        check("ign_hi", HI, 32'd0);
        check("ign_lo", LO, 32'd12);
        @(negedge clk);
        check("ign_no_restart", 32'(Busy), 32'd0);

`ifdef MDU_MADD_EN
        do_op(4'd7, 32'd0, 32'd0, 0, 32'd0, 32'd12);
        do_op(4'd8, 32'hFFFFFFFF, 32'd0, 0, 32'd0, 32'hFFFFFFFF);
        do_op(4'd10, 32'd1, 32'd1, 5, 32'd1, 32'd0);
        do_op(4'd9, 32'hFFFFFFFF, 32'd1, 5, 32'd0, 32'hFFFFFFFF);
`else
        @(negedge clk);
        MDUOp_E = 4'd9; SrcA_E = 32'd1; SrcB_E = 32'd1; MDUUse_D = 1'b1;
        #1 check("op9_stall", 32'(MDU_Stall), 32'd0);
        @(negedge clk);
        MDUOp_E = 4'd0; MDUUse_D = 1'b0;
        check("op9_busy", 32'(Busy), 32'd0);
        repeat (6) @(negedge clk);
        check("op9_hi", HI, 32'd0);
        check("op9_lo", LO, 32'd12);
`endif

        // reset in cycle t+2 of a divide aborts it
        @(negedge clk);
        MDUOp_E = 4'd3; SrcA_E = 32'd100; SrcB_E = 32'd7;
        @(negedge clk);
        MDUOp_E = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_late_hi", HI, 32'd0);
        check("abort_late_lo", LO, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
